cache_tag_ctrl: RTL
===================

Name: cache_tag_ctrl

Overview:
- Sequences all writes into the 4-way virtual/physical cache tag array.
- Arbitrates between a refill requester (the miss handler) and an invalidate requester (snoop/flush).
- For a refill, it checks whether the virtual tag is already present in some way and reuses that way; otherwise it picks a victim way with a per-line round-robin pointer.
- It then issues a single one-cycle tag write and signals completion.

Parameters:
- LINES, 64, number of lines per way.
- WAYS, 4, number of ways; fixed at 4 because the tag-array way port is 2 bits.
- LOBIT, 6, low bit of the line index in the address.
- HIBIT, $clog2(LINES)-1+LOBIT, high bit of the line index.
- TAGBIT, HIBIT+2, low bit of the stored tag field.
- INV_STARVE, 4, number of consecutive invalidate grants after which a pending refill wins.

Ports:
- rst  in  1  async active-high reset
- clk  in  1  clock
- rfl_req  in  1  refill request
- rfl_vadr  in  address_t  refill virtual address
- rfl_padr  in  address_t  refill physical address
- rfl_rdy  out  1  refill accepted this cycle
- rfl_done  out  1  one-cycle pulse: refill tag written
- rfl_way  out  2  way written; valid while rfl_done=1
- inv_req  in  1  invalidate request
- inv_vadr  in  address_t  address to invalidate (index bits used)
- inv_way  in  2  way to invalidate
- inv_rdy  out  1  invalidate accepted this cycle
- inv_done  out  1  one-cycle pulse: invalidate written
- tag_ce  out  1  tag array clock enable
- tag_wr  out  1  tag array write strobe
- tag_way  out  2  tag array way select
- tag_vadr  out  address_t  tag array virtual address
- tag_padr  out  address_t  tag array physical address
- tag_ndx  out  $clog2(LINES)  tag array read index
- tag_i  in  cache_tag_t [WAYS]  virtual tags read at tag_ndx

Behaviour:
- Clock and reset: clk, rst. rst is asynchronous, active-high.
- Reset values:
  - state=IDLE; all outputs 0; tag_ce=1.
  - All round-robin pointers 0; starvation counter 0.
- IDLE state:
  - rfl_rdy and inv_rdy are high combinationally only for the granted requester.
  - Acceptance happens when req && rdy in the same cycle; address, way and kind are latched.
- Arbitration:
  - Invalidate has priority.
  - If a refill is pending and the starvation count reaches INV_STARVE, the refill is granted and the count clears.
  - The count increments on each invalidate grant made while rfl_req=1, and clears on any refill grant.
- States and transitions:
  - IDLE -> LOOKUP on an accepted refill.
  - IDLE -> WRITE on an accepted invalidate.
  - LOOKUP -> WRITE.
  - WRITE -> DONE.
  - DONE -> IDLE.
- LOOKUP:
  - tag_ndx = latched vadr[HIBIT:LOBIT].
  - Compare tag_i[w] against vadr[$bits(address_t)-1:TAGBIT]. The lowest matching way is chosen (reuse).
  - With no match, the way is rr_ptr[ndx], and rr_ptr[ndx] increments modulo 4, wrapping 3->0.
  - A reuse does not advance the pointer.
- WRITE:
  - tag_wr=1 for exactly one cycle; tag_way = chosen way.
  - Refill: tag_vadr = vadr and tag_padr = padr.
  - Invalidate: both are the latched address with tag field [$bits(address_t)-1:TAGBIT] forced to 1, the reset/invalid tag value; index bits are kept.
- DONE:
  - Refill: rfl_done=1 with rfl_way.
  - Invalidate: inv_done=1.
- Latency:
  - Refill: accept cycle N, write N+2, done N+3.
  - Invalidate: write N+1, done N+2.
- Simultaneous requests: resolved by the arbitration rule; the loser's rdy stays low and its req must stay held.
- Requests arriving outside IDLE are not accepted; rdy stays 0.
- Reset asserted mid-operation aborts immediately; no tag_wr is issued after reset.
- An invalidate to an index whose refill is in flight is serialized (one outstanding op), so no hazard exists.

Optional Feature:
- CACHE_TAG_CTRL_STATS_EN defined:
  - Adds three 32-bit saturating counters: refills, reuse-hits and invalidates.
  - Counters reset to 0 and are exposed on output ports stat_rfl, stat_reuse and stat_inv.
  - Counters hold at 0xFFFFFFFF.
- Undefined: counters and ports are absent.

Decomposition:
- cache_pkg: add tag_ctrl_state_t enum (IDLE, LOOKUP, WRITE, DONE) and the constant CACHE_TAG_INVALID='d1.
- address_t comes from cpu_types_pkg; cache_tag_t from cache_pkg.
- One sub-module: cache_way_rr. It holds the LINES x 2-bit round-robin pointer array with read-index, advance strobe and async reset.

Test Plan (32-bit address, LINES=64: index=[11:6], tag=[31:13]):
- Reset, then refill vadr=0x00010040 with all tags 1 -> tag_wr at N+2, way 0, ndx 1, stored tag 0x8; rfl_done at N+3 with rfl_way=0; rr_ptr[1]=1.
- Refill the same index 1 four more times with distinct tags and no match -> ways 1,2,3,0 in order (wrap-around).
- tag_i[2]=0x8 at ndx 1, refill 0x00010040 -> rfl_way=2; rr_ptr[1] unchanged.
- inv_req and rfl_req both held high -> invalidates granted 4 times, then the refill is granted; the 5th invalidate waits for its completion.
- Invalidate vadr=0x00010040, way 3 -> tag_wr at N+1, tag_way=3, tag_vadr[31:13]=1 with index 1; inv_done at N+2.
- Assert rst during LOOKUP -> outputs return to reset values at once; no tag_wr; rfl_done never pulses.

Source files
------------

// File: rtl/cache_pkg.sv
// Cache tag types, tag-controller state encoding and the invalid tag value.
package cache_pkg;
   import cpu_types_pkg::*;

   localparam int CACHE_LINES  = 64;
   localparam int CACHE_LOBIT  = 6;
   localparam int CACHE_TAGBIT = $clog2(CACHE_LINES) - 1 + CACHE_LOBIT + 2;
   localparam int CACHE_TAG_W  = ADDR_W - CACHE_TAGBIT;

   typedef logic [CACHE_TAG_W-1:0] cache_tag_t;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, DONE} tag_ctrl_state_t;

   localparam cache_tag_t CACHE_TAG_INVALID = 'd1;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine address.
package cpu_types_pkg;
   localparam int ADDR_W = 32;
   typedef logic [ADDR_W-1:0] address_t;
endpackage

// File: rtl/cache_way_rr.sv
// Per-line 2-bit round-robin victim pointers; the indexed pointer advances on adv_i.
module cache_way_rr #(
   parameter int LINES = 64,
   localparam int NDX_W = $clog2(LINES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NDX_W-1:0] ndx_i,
   input  logic             adv_i,
   output logic [1:0]       ptr_o
);
   logic [LINES-1:0][1:0] ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (adv_i) begin
         ptr_q[ndx_i] <= ptr_q[ndx_i] + 2'd1;
      end
   end

   assign ptr_o = ptr_q[ndx_i];
endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag-array write sequencer: arbitrates refill vs invalidate, picks a way, issues one tag write.
// Optional CACHE_TAG_CTRL_STATS_EN adds saturating refill/reuse/invalidate counters.
module cache_tag_ctrl
   import cpu_types_pkg::*;
   import cache_pkg::*;
#(
   parameter int LINES      = 64,
   parameter int WAYS       = 4,
   parameter int LOBIT      = 6,
   parameter int HIBIT      = $clog2(LINES) - 1 + LOBIT,
   parameter int TAGBIT     = HIBIT + 2,
   parameter int INV_STARVE = 4
) (
   input  logic                     rst,
   input  logic                     clk,
   input  logic                     rfl_req,
   input  address_t                 rfl_vadr,
   input  address_t                 rfl_padr,
   output logic                     rfl_rdy,
   output logic                     rfl_done,
   output logic [1:0]               rfl_way,
   input  logic                     inv_req,
   input  address_t                 inv_vadr,
   input  logic [1:0]               inv_way,
   output logic                     inv_rdy,
   output logic                     inv_done,
   output logic                     tag_ce,
   output logic                     tag_wr,
   output logic [1:0]               tag_way,
   output address_t                 tag_vadr,
   output address_t                 tag_padr,
   output logic [$clog2(LINES)-1:0] tag_ndx,
   input  cache_tag_t               tag_i [WAYS]
`ifdef CACHE_TAG_CTRL_STATS_EN
   ,
   output logic [31:0]              stat_rfl,
   output logic [31:0]              stat_reuse,
   output logic [31:0]              stat_inv
`endif
);
   localparam int SW = $clog2(INV_STARVE + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(INV_STARVE);

   tag_ctrl_state_t state_q, state_d;
   address_t        addr_q, addr_d;
   address_t        padr_q, padr_d;
   logic            inv_q, inv_d;
   logic [1:0]      way_q, way_d;
   logic [SW-1:0]   starve_q, starve_d;

   logic            hit;
   logic [1:0]      hit_way;
   logic [1:0]      rr_ptr;
   logic            rr_adv;
   logic            rfl_win;
   address_t        inv_addr;

   cache_way_rr #(.LINES(LINES)) u_rr (
      .clk   (clk),
      .rst   (rst),
      .ndx_i (addr_q[HIBIT:LOBIT]),
      .adv_i (rr_adv),
      .ptr_o (rr_ptr)
   );

   // Scan downwards so the lowest matching way is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (tag_i[w] == addr_q[$bits(address_t)-1:TAGBIT]) begin
            hit     = 1'b1;
            hit_way = 2'(w);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      padr_d   = padr_q;
      inv_d    = inv_q;
      way_d    = way_q;
      starve_d = starve_q;
      rfl_rdy  = 1'b0;
      inv_rdy  = 1'b0;
      rr_adv   = 1'b0;
      rfl_win  = rfl_req && (!inv_req || starve_q >= STARVE_MAX);
      case (state_q)
         IDLE: begin
            if (rfl_win) begin
               rfl_rdy  = 1'b1;
               addr_d   = rfl_vadr;
               padr_d   = rfl_padr;
               inv_d    = 1'b0;
               starve_d = '0;
               state_d  = LOOKUP;
            end else if (inv_req) begin
               inv_rdy = 1'b1;
               addr_d  = inv_vadr;
               way_d   = inv_way;
               inv_d   = 1'b1;
               if (rfl_req) starve_d = starve_q + 1'b1;
               state_d = WRITE;
            end
         end
         LOOKUP: begin
            way_d   = hit ? hit_way : rr_ptr;
            rr_adv  = !hit;
            state_d = WRITE;
         end
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         padr_q   <= '0;
         inv_q    <= 1'b0;
         way_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         padr_q   <= padr_d;
         inv_q    <= inv_d;
         way_q    <= way_d;
         starve_q <= starve_d;
      end
   end

   // Invalidation stores the invalid tag but keeps the index bits of the address.
   always_comb begin
      inv_addr = addr_q;
      inv_addr[$bits(address_t)-1:TAGBIT] = CACHE_TAG_INVALID;
   end

   assign tag_ce   = 1'b1;
   assign tag_wr   = (state_q == WRITE);
   assign tag_way  = tag_wr ? way_q : 2'd0;
   assign tag_vadr = tag_wr ? (inv_q ? inv_addr : addr_q) : '0;
   assign tag_padr = tag_wr ? (inv_q ? inv_addr : padr_q) : '0;
   assign tag_ndx  = addr_q[HIBIT:LOBIT];
   assign rfl_done = (state_q == DONE) && !inv_q;
   assign inv_done = (state_q == DONE) && inv_q;
   assign rfl_way  = rfl_done ? way_q : 2'd0;

`ifdef CACHE_TAG_CTRL_STATS_EN
   logic [31:0] stat_rfl_q, stat_reuse_q, stat_inv_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rfl_q   <= '0;
         stat_reuse_q <= '0;
         stat_inv_q   <= '0;
      end else begin
         if (rfl_req && rfl_rdy && stat_rfl_q != '1)       stat_rfl_q   <= stat_rfl_q + 32'd1;
         if (state_q == LOOKUP && hit && stat_reuse_q != '1) stat_reuse_q <= stat_reuse_q + 32'd1;
         if (inv_req && inv_rdy && stat_inv_q != '1)       stat_inv_q   <= stat_inv_q + 32'd1;
      end
   end

   assign stat_rfl   = stat_rfl_q;
   assign stat_reuse = stat_reuse_q;
   assign stat_inv   = stat_inv_q;
`endif
endmodule
